// File: rtl/ps_arb_fifo.sv
// Round-robin arbiter feeding a shared first-word-fall-through request queue.
// One enqueue per cycle from the granted channel; the head entry is presented combinationally.
module ps_arb_fifo #(
    parameter int NUM_CH       = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NODE_WIDTH   = 8,
    parameter int DEPTH        = 128,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flush,
    input  logic [NUM_CH-1:0]                           in_valid,
    output logic [NUM_CH-1:0]                           in_ready,
    input  logic [NUM_CH*NODE_WIDTH-1:0]                in_node,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]                in_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                in_wdata,
    input  logic [NUM_CH-1:0]                           in_we,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [NODE_WIDTH-1:0]                       out_node,
    output logic [ADDR_WIDTH-1:0]                       out_addr,
    output logic [DATA_WIDTH-1:0]                       out_wdata,
    output logic                                        out_we,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic [$clog2(DEPTH+1)-1:0]                  count,
    output logic                                        full,
    output logic                                        empty,
    output logic                                        almost_full
);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = NODE_WIDTH + ADDR_WIDTH + DATA_WIDTH + 1 + CH_W;

    logic [NODE_WIDTH-1:0] node_arr  [NUM_CH];
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CH];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_CH];

    logic [CH_W-1:0]    p_reg;
    logic [CH_W-1:0]    grant_idx;
    logic [CH_W-1:0]    cand;
    logic               grant_any;
    logic               accept_ok;
    logic               enq;
    logic               deq;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] entry_in;

    logic [NODE_WIDTH-1:0] head_node;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic                  head_we;
    logic [CH_W-1:0]       head_ch;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign node_arr[gi]  = in_node[gi*NODE_WIDTH +: NODE_WIDTH];
            assign addr_arr[gi]  = in_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = in_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign in_ready[gi]  = accept_ok && grant_any && (grant_idx == CH_W'(gi));
        end
    endgenerate

    // First valid channel at or after the priority pointer, wrapping modulo NUM_CH.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(p_reg) + k) % NUM_CH);
            if (!grant_any && in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // rst_n gates acceptance so in_ready is low for the whole reset interval.
    assign accept_ok = rst_n && !full && !flush;
    assign enq       = grant_any && accept_ok;
    assign deq       = out_valid && out_ready && !flush;
    assign entry_in  = {node_arr[grant_idx], addr_arr[grant_idx], wdata_arr[grant_idx],
                        in_we[grant_idx], grant_idx};

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_reg] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg      <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                p_reg      <= CH_W'((int'(grant_idx) + 1) % NUM_CH);
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign {head_node, head_addr, head_wdata, head_we, head_ch} = mem[rd_ptr_reg];

    assign count       = count_reg;
    assign full        = (count_reg == CNT_W'(DEPTH));
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= CNT_W'(AFULL_THRESH));
    assign out_valid   = !empty;

    // Payload is forced to zero when idle so stale storage never leaks out.
    assign out_node  = out_valid ? head_node  : '0;
    assign out_addr  = out_valid ? head_addr  : '0;
    assign out_wdata = out_valid ? head_wdata : '0;
    assign out_we    = out_valid ? head_we    : 1'b0;
    assign out_ch    = out_valid ? head_ch    : '0;
endmodule

// File: tb/tb_ps_arb_fifo.sv
// Directed bench for ps_arb_fifo: a DEPTH=4 instance for most checks and a
// DEPTH=8 instance sharing the same inputs for the five-entry reset case.
module tb_ps_arb_fifo;
    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NW = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic [NC-1:0]    in_valid = '0;
    logic [NC-1:0]    in_we = '0;
    logic [NC*NW-1:0] in_node = '0;
    logic [NC*AW-1:0] in_addr = '0;
    logic [NC*DW-1:0] in_wdata = '0;

    logic [NC-1:0] in_ready, b_in_ready;
    logic          out_valid, b_out_valid;
    logic [NW-1:0] out_node, b_out_node;
    logic [AW-1:0] out_addr, b_out_addr;
    logic [DW-1:0] out_wdata, b_out_wdata;
    logic          out_we, b_out_we;
    logic [1:0]    out_ch, b_out_ch;
    logic [2:0]    count;
    logic [3:0]    b_count;
    logic          full, empty, almost_full;
    logic          b_full, b_empty, b_almost_full;

    int n_checks = 0;
    int n_fail   = 0;

    ps_arb_fifo #(.NUM_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NODE_WIDTH(NW),
                  .DEPTH(4), .AFULL_THRESH(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_node(in_node),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_node(out_node),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_we(out_we),
        .out_ch(out_ch), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full)
    );

    ps_arb_fifo #(.NUM_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NODE_WIDTH(NW),
                  .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_node(in_node),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_we(in_we),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_node(b_out_node),
        .out_addr(b_out_addr), .out_wdata(b_out_wdata), .out_we(b_out_we),
        .out_ch(b_out_ch), .count(b_count), .full(b_full), .empty(b_empty),
        .almost_full(b_almost_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Payload of channel ch derived from its address so expectations are easy to recompute.
    task automatic load(input int ch, input logic [AW-1:0] a);
        in_node[ch*NW +: NW]  = NW'(8'h10 + ch);
        in_addr[ch*AW +: AW]  = a;
        in_wdata[ch*DW +: DW] = a ^ 16'h5A5A;
        in_we[ch]             = a[0];
    endtask

    initial begin
        // Reset state, with requests already pending.
        for (int i = 0; i < NC; i++) load(i, AW'(16'h100 + i));
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #2;
        check_eq("rst count", count, 0);
        check_eq("rst empty", empty, 1);
        check_eq("rst full", full, 0);
        check_eq("rst afull", almost_full, 0);
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst in_ready", in_ready, 0);
        #5;
        rst_n = 1'b1;

        // Round-robin with all channels requesting and the consumer always ready.
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("arb in_ready", in_ready, 64'(1 << (k % 4)));
            if (k > 0) begin
                check_eq("arb out_ch", out_ch, 64'((k - 1) % 4));
                check_eq("arb out_addr", out_addr, 64'(16'h100 + (k - 1) % 4));
                check_eq("arb count", count, 1);
            end
            tick();
        end
        in_valid = '0;
        #1;
        check_eq("arb last out_ch", out_ch, 3);
        tick();
        check_eq("arb drained empty", empty, 1);

        // Fill a DEPTH=4 queue from channel 1 with the consumer stalled.
        out_ready = 1'b0;
        for (int a = 1; a <= 4; a++) begin
            load(1, AW'(a));
            in_valid = 4'b0010;
            #1;
            check_eq("fill in_ready", in_ready, 4'b0010);
            tick();
            check_eq("fill count", count, 64'(a));
            check_eq("fill afull", almost_full, 64'(a >= 3));
        end
        load(1, 16'd5);
        #1;
        check_eq("full flag", full, 1);
        check_eq("full in_ready", in_ready, 0);
        check_eq("full head addr", out_addr, 1);
        check_eq("full head wdata", out_wdata, 16'h5A5B);
        check_eq("full head node", out_node, 8'h11);
        check_eq("full head we", out_we, 1);
        out_ready = 1'b1;
        #1;
        check_eq("full deq in_ready", in_ready, 0);
        tick();
        out_ready = 1'b0;
        #1;
        check_eq("after deq count", count, 3);
        check_eq("after deq head", out_addr, 2);
        check_eq("reopen in_ready", in_ready, 4'b0010);
        tick();
        check_eq("addr5 accepted", count, 4);
        in_valid = '0;
        out_ready = 1'b1;
        for (int e = 2; e <= 5; e++) begin
            #1;
            check_eq("drain order", out_addr, 64'(e));
            tick();
            check_eq("drain count", count, 64'(5 - e));
            check_eq("drain afull", almost_full, 64'((5 - e) >= 3));
        end
        check_eq("drain empty", empty, 1);

        // Concurrent enqueue/dequeue at count 2, running the pointers around several times.
        out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            load(2, AW'(16'h40 + j));
            in_valid = 4'b0100;
            tick();
        end
        check_eq("wrap preload", count, 2);
        out_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            load(2, AW'(16'h40 + j + 2));
            #1;
            check_eq("wrap order", out_addr, 64'(16'h40 + j));
            tick();
            check_eq("wrap count", count, 2);
        end
        out_ready = 1'b0;
        load(2, 16'h4E);
        tick();
        check_eq("pre-flush count", count, 3);

        // Flush beats a concurrent request; priority pointer is kept.
        load(0, 16'h77);
        in_valid = 4'b0001;
        flush = 1'b1;
        #1;
        check_eq("flush in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = '0;
        #1;
        check_eq("flush count", count, 0);
        check_eq("flush empty", empty, 1);
        check_eq("flush out_valid", out_valid, 0);
        check_eq("flush out_addr", out_addr, 0);
        check_eq("flush out_node", out_node, 0);
        check_eq("flush out_wdata", out_wdata, 0);
        check_eq("flush out_we", out_we, 0);
        check_eq("flush out_ch", out_ch, 0);
        in_valid = 4'hF;
        #1;
        check_eq("flush keeps p", in_ready, 4'b1000);
        in_valid = '0;

        // Five entries into the DEPTH=8 copy, then an unaligned asynchronous reset.
        for (int j = 0; j < 5; j++) begin
            load(0, AW'(16'h60 + j));
            in_valid = 4'b0001;
            tick();
        end
        check_eq("pre-reset count8", b_count, 5);
        check_eq("pre-reset count4", count, 4);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("areset count8", b_count, 0);
        check_eq("areset empty8", b_empty, 1);
        check_eq("areset out_valid8", b_out_valid, 0);
        check_eq("areset out_addr8", b_out_addr, 0);
        check_eq("areset in_ready8", b_in_ready, 0);
        check_eq("areset count4", count, 0);
        check_eq("areset full4", full, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        in_valid = 4'hF;
        #1;
        check_eq("reset clears p", in_ready, 4'b0001);
        load(2, 16'h99);
        in_valid = 4'b0100;
        #1;
        check_eq("post-reset grant", in_ready, 4'b0100);
        check_eq("post-reset grant8", b_in_ready, 4'b0100);
        tick();
        in_valid = '0;
        check_eq("post-reset out_valid", out_valid, 1);
        check_eq("post-reset out_ch", out_ch, 2);
        check_eq("post-reset out_addr", out_addr, 16'h99);
        check_eq("post-reset out_ch8", b_out_ch, 2);
        check_eq("post-reset count", count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
